// File: rtl/fwd_if.sv
// ID-stage to forwarding-controller bundle: decoded register usage in, EX operand selects and stall out.
interface fwd_if #(
    parameter int AW = 5
);
    logic          en;
    logic          flush;
    logic [AW-1:0] id_rs;
    logic [AW-1:0] id_rt;
    logic          id_use_rs;
    logic          id_use_rt;
    logic [AW-1:0] id_dst;
    logic          id_we;
    logic          id_load;
    logic [1:0]    fwd_a_sel;
    logic [1:0]    fwd_b_sel;
    logic          stall;

    modport master (
        output en, flush, id_rs, id_rt, id_use_rs, id_use_rt, id_dst, id_we, id_load,
        input  fwd_a_sel, fwd_b_sel, stall
    );

    modport slave (
        input  en, flush, id_rs, id_rt, id_use_rs, id_use_rt, id_dst, id_we, id_load,
        output fwd_a_sel, fwd_b_sel, stall
    );
endinterface

// File: rtl/fwd_ctrl.sv
// Forwarding and load-use hazard controller for the 5-stage pipeline.
// Tracks destinations through EX/MEM/WB and produces registered EX operand selects.
module fwd_ctrl #(
    parameter int AW     = 5,
    parameter int FWD_R0 = 0
) (
    input  logic  clk,
    input  logic  rst_n,
    fwd_if.slave  bus
);
    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_WB  = 2'b10;

    logic [AW-1:0] ex_dst_r;
    logic          ex_we_r;
    logic          ex_load_r;
    logic [AW-1:0] mem_dst_r;
    logic          mem_we_r;
    logic          mem_load_r;
    logic [AW-1:0] wb_dst_r;
    logic          wb_we_r;
    logic [1:0]    sel_a_r;
    logic [1:0]    sel_b_r;

    logic          hz_s;
    logic          stall_s;
    logic          bubble_s;
    logic [1:0]    sel_a_s;
    logic [1:0]    sel_b_s;

    // Register 0 is hardwired to zero unless forwarding of it is explicitly allowed.
    function automatic logic match_f(input logic [AW-1:0] r,
                                     input logic [AW-1:0] dst,
                                     input logic          we);
        return we && (dst == r) && ((FWD_R0 != 0) || (r != {AW{1'b0}}));
    endfunction

    // Hazard detection and operand select computation from the ID instruction and slots.
    always_comb begin
        hz_s     = 1'b0;
        stall_s  = 1'b0;
        bubble_s = 1'b0;
        sel_a_s  = SEL_RF;
        sel_b_s  = SEL_RF;

        hz_s = (bus.id_use_rs && match_f(bus.id_rs, ex_dst_r, ex_we_r) && ex_load_r) ||
               (bus.id_use_rt && match_f(bus.id_rt, ex_dst_r, ex_we_r) && ex_load_r);
        stall_s  = hz_s && !bus.flush;
        bubble_s = bus.flush || stall_s;

        // EX-slot match is checked first so the newest producer wins.
        if (bus.id_use_rs && match_f(bus.id_rs, ex_dst_r, ex_we_r) && !ex_load_r) begin
            sel_a_s = SEL_MEM;
        end else if (bus.id_use_rs && match_f(bus.id_rs, mem_dst_r, mem_we_r)) begin
            sel_a_s = SEL_WB;
        end else begin
            sel_a_s = SEL_RF;
        end

        if (bus.id_use_rt && match_f(bus.id_rt, ex_dst_r, ex_we_r) && !ex_load_r) begin
            sel_b_s = SEL_MEM;
        end else if (bus.id_use_rt && match_f(bus.id_rt, mem_dst_r, mem_we_r)) begin
            sel_b_s = SEL_WB;
        end else begin
            sel_b_s = SEL_RF;
        end
    end

    // MEM and WB slots advance only with the pipeline enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_dst_r  <= {AW{1'b0}};
            mem_we_r   <= 1'b0;
            mem_load_r <= 1'b0;
            wb_dst_r   <= {AW{1'b0}};
            wb_we_r    <= 1'b0;
        end else if (bus.en) begin
            mem_dst_r  <= ex_dst_r;
            mem_we_r   <= ex_we_r;
            mem_load_r <= ex_load_r;
            wb_dst_r   <= mem_dst_r;
            wb_we_r    <= mem_we_r;
        end else begin
            mem_dst_r  <= mem_dst_r;
            mem_we_r   <= mem_we_r;
            mem_load_r <= mem_load_r;
            wb_dst_r   <= wb_dst_r;
            wb_we_r    <= wb_we_r;
        end
    end

    // EX slot and registered selects; a flush bubbles EX even while the pipeline is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_dst_r  <= {AW{1'b0}};
            ex_we_r   <= 1'b0;
            ex_load_r <= 1'b0;
            sel_a_r   <= SEL_RF;
            sel_b_r   <= SEL_RF;
        end else if (bus.flush || (bus.en && bubble_s)) begin
            ex_dst_r  <= {AW{1'b0}};
            ex_we_r   <= 1'b0;
            ex_load_r <= 1'b0;
            sel_a_r   <= SEL_RF;
            sel_b_r   <= SEL_RF;
        end else if (bus.en) begin
            ex_dst_r  <= bus.id_dst;
            ex_we_r   <= bus.id_we;
            ex_load_r <= bus.id_load;
            sel_a_r   <= sel_a_s;
            sel_b_r   <= sel_b_s;
        end else begin
            ex_dst_r  <= ex_dst_r;
            ex_we_r   <= ex_we_r;
            ex_load_r <= ex_load_r;
            sel_a_r   <= sel_a_r;
            sel_b_r   <= sel_b_r;
        end
    end

    assign bus.fwd_a_sel = sel_a_r;
    assign bus.fwd_b_sel = sel_b_r;
    assign bus.stall     = stall_s;

endmodule
